// File: rtl/fetch_f1_pkg.sv
// Shared definitions for the F1 fetch stage: BTB counter encodings, FSM states,
// the BTB read record and counter training helpers.
package fetch_f1_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
   localparam int unsigned DEFAULT_BTB_ENTRIES = 64;
   localparam logic [31:0] GROUP_BYTES         = 32'd8;

   typedef enum logic [1:0] {
      CTR_SNT = 2'd0,
      CTR_WNT = 2'd1,
      CTR_WT  = 2'd2,
      CTR_ST  = 2'd3
   } ctr_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   typedef struct packed {
      logic        hit;
      ctr_e        ctr;
      logic [31:0] tgt;
   } btb_rd_t;

   function automatic ctr_e ctr_train(ctr_e cur, logic taken);
      ctr_e nxt;
      nxt = cur;
      if (taken) begin
         if (cur != CTR_ST) nxt = ctr_e'(cur + 2'd1);
      end else begin
         if (cur != CTR_SNT) nxt = ctr_e'(cur - 2'd1);
      end
      return nxt;
   endfunction

   function automatic logic ctr_predicts_taken(ctr_e cur);
      return (cur == CTR_WT) || (cur == CTR_ST);
   endfunction

endpackage

// File: rtl/fetch_f1_if.sv
// Fetch-stage bundle: frontend control, execute redirect/training and the F1 outputs.
// fetch_f1 takes the slave side; the pipeline/execute environment takes the master side.
interface fetch_f1_if;

   logic        frontend_we_i;
   logic        exec_wrong_branch_i;
   logic [31:0] exec_redirect_pc_i;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic        btb_flush_i;

   logic [31:0] f1_pc_o;
   logic        f1_pred_0_o;
   logic        f1_pred_1_o;
   logic [31:0] f1_pred_tgt_0_o;
   logic [31:0] f1_pred_tgt_1_o;
   logic [31:0] f1_next_pc_o;
   logic        f1_stall_o;

   modport slave (
      input  frontend_we_i, exec_wrong_branch_i, exec_redirect_pc_i,
      input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, btb_flush_i,
      output f1_pc_o, f1_pred_0_o, f1_pred_1_o, f1_pred_tgt_0_o, f1_pred_tgt_1_o,
      output f1_next_pc_o, f1_stall_o
   );

   modport master (
      output frontend_we_i, exec_wrong_branch_i, exec_redirect_pc_i,
      output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, btb_flush_i,
      input  f1_pc_o, f1_pred_0_o, f1_pred_1_o, f1_pred_tgt_0_o, f1_pred_tgt_1_o,
      input  f1_next_pc_o, f1_stall_o
   );

endinterface

// File: rtl/fetch_f1_btb.sv
// Direct-mapped BTB: two combinational read ports, one training write port and a
// one-entry-per-cycle clear port. Addresses are word addresses (pc[31:2]).
module fetch_f1_btb
   import fetch_f1_pkg::*;
#(
   parameter  int unsigned ENTRIES = DEFAULT_BTB_ENTRIES,
   localparam int unsigned IDX_W   = $clog2(ENTRIES),
   localparam int unsigned TAG_W   = 30 - IDX_W
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic [29:0]      rd_addr_0_i,
   input  logic [29:0]      rd_addr_1_i,
   output btb_rd_t          rd_0_o,
   output btb_rd_t          rd_1_o,
   input  logic             upd_en_i,
   input  logic [29:0]      upd_addr_i,
   input  logic             upd_taken_i,
   input  logic [31:0]      upd_target_i,
   input  logic             clr_en_i,
   input  logic [IDX_W-1:0] clr_idx_i
);

   logic [ENTRIES-1:0] valid_q;
   ctr_e               ctr_q [ENTRIES];
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];

   logic [IDX_W-1:0] rd_idx_0, rd_idx_1, upd_idx;
   logic [TAG_W-1:0] rd_tag_0, rd_tag_1, upd_tag;
   logic             upd_hit;
   logic             meta_we;
   logic             data_we;
   ctr_e             ctr_d;

   assign rd_idx_0 = rd_addr_0_i[IDX_W-1:0];
   assign rd_tag_0 = rd_addr_0_i[29:IDX_W];
   assign rd_idx_1 = rd_addr_1_i[IDX_W-1:0];
   assign rd_tag_1 = rd_addr_1_i[29:IDX_W];

   // NOTE: combinational blocks use blocking '=' and assign every output a default
   // first, so no path can leave a value held over and infer a latch.
   always_comb begin
      rd_0_o     = '0;
      rd_1_o     = '0;
      rd_0_o.hit = valid_q[rd_idx_0] && (tag_q[rd_idx_0] == rd_tag_0);
      rd_0_o.ctr = ctr_q[rd_idx_0];
      rd_0_o.tgt = tgt_q[rd_idx_0];
      rd_1_o.hit = valid_q[rd_idx_1] && (tag_q[rd_idx_1] == rd_tag_1);
      rd_1_o.ctr = ctr_q[rd_idx_1];
      rd_1_o.tgt = tgt_q[rd_idx_1];
   end

   assign upd_idx = upd_addr_i[IDX_W-1:0];
   assign upd_tag = upd_addr_i[29:IDX_W];
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   // A taken resolution always (re)writes tag and target: on a hit the tag is unchanged,
   // on a miss it allocates. A not-taken miss leaves the entry alone.
   assign meta_we = upd_en_i && (upd_hit || upd_taken_i);
   assign data_we = upd_en_i && upd_taken_i;
   assign ctr_d   = upd_hit ? ctr_train(ctr_q[upd_idx], upd_taken_i) : CTR_WT;

   // NOTE: sequential state uses non-blocking '<=' so every register samples the
   // pre-edge values, regardless of statement order.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid_q <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CTR_SNT;
      end else if (clr_en_i) begin
         valid_q[clr_idx_i] <= 1'b0;
         ctr_q[clr_idx_i]   <= CTR_SNT;
      end else if (meta_we) begin
         valid_q[upd_idx] <= 1'b1;
         ctr_q[upd_idx]   <= ctr_d;
      end
   end

   // NOTE: tag and target arrays have no reset; every use of them is qualified by
   // the valid bit, which is reset, so they can map onto plain RAM.
   always_ff @(posedge clock_i) begin
      if (data_we) begin
         tag_q[upd_idx] <= upd_tag;
         tgt_q[upd_idx] <= upd_target_i;
      end
   end

endmodule

// File: rtl/fetch_f1.sv
// F1 fetch stage: PC register, next-PC selection and the RUN/CLEAR BTB flush FSM.
// Build option: define BRANCH_PRED_EN to build the BTB; otherwise predictions are tied off.
module fetch_f1
   import fetch_f1_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int unsigned BTB_ENTRIES = DEFAULT_BTB_ENTRIES
) (
   input logic       clock_i,
   input logic       reset_n_i,
   fetch_f1_if.slave bus
);

   localparam int unsigned      IDX_W    = $clog2(BTB_ENTRIES);
   localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(BTB_ENTRIES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      next_pc;
   logic             clearing;

   logic             pred_0, pred_1;
   logic [31:0]      tgt_0, tgt_1;

   assign clearing = (state_q == ST_CLEAR);

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_RUN;
         clr_idx_q <= '0;
         pc_q      <= RESET_PC;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         pc_q      <= pc_d;
      end
   end

   // Flush requests are only accepted in RUN; CLEAR walks every index exactly once.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      unique case (state_q)
         ST_RUN: begin
            if (bus.btb_flush_i) begin
               state_d   = ST_CLEAR;
               clr_idx_d = '0;
            end
         end
         ST_CLEAR: begin
            if (clr_idx_q == CLR_LAST) state_d = ST_RUN;
            else                       clr_idx_d = clr_idx_q + IDX_W'(1);
         end
         default: state_d = ST_RUN;
      endcase
   end

`ifdef BRANCH_PRED_EN
   logic [29:0] slot1_addr;
   btb_rd_t     rd_0, rd_1;

   assign slot1_addr = pc_q[31:2] + 30'd1;

   fetch_f1_btb #(
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clock_i      (clock_i),
      .reset_n_i    (reset_n_i),
      .rd_addr_0_i  (pc_q[31:2]),
      .rd_addr_1_i  (slot1_addr),
      .rd_0_o       (rd_0),
      .rd_1_o       (rd_1),
      .upd_en_i     (bus.upd_valid_i && !clearing),
      .upd_addr_i   (bus.upd_pc_i[31:2]),
      .upd_taken_i  (bus.upd_taken_i),
      .upd_target_i (bus.upd_target_i),
      .clr_en_i     (clearing),
      .clr_idx_i    (clr_idx_q)
   );

   // Slot 1 is only reported when slot 0 does not already redirect the group.
   always_comb begin
      pred_0 = 1'b0;
      tgt_0  = '0;
      pred_1 = 1'b0;
      tgt_1  = '0;
      if (!clearing && rd_0.hit) begin
         tgt_0  = rd_0.tgt;
         pred_0 = ctr_predicts_taken(rd_0.ctr);
      end
      if (!clearing && rd_1.hit && !pred_0) begin
         tgt_1  = rd_1.tgt;
         pred_1 = ctr_predicts_taken(rd_1.ctr);
      end
   end
`else
   always_comb begin
      pred_0 = 1'b0;
      tgt_0  = '0;
      pred_1 = 1'b0;
      tgt_1  = '0;
   end
`endif

   always_comb begin
      next_pc = pc_q + GROUP_BYTES;
      if (bus.exec_wrong_branch_i) next_pc = bus.exec_redirect_pc_i;
      else if (pred_0)             next_pc = tgt_0;
      else if (pred_1)             next_pc = tgt_1;
   end

   // Redirects bypass the frontend enable so a held redirect simply reloads the same PC.
   assign pc_d = (bus.frontend_we_i || bus.exec_wrong_branch_i) ? next_pc : pc_q;

   assign bus.f1_pc_o         = pc_q;
   assign bus.f1_pred_0_o     = pred_0;
   assign bus.f1_pred_1_o     = pred_1;
   assign bus.f1_pred_tgt_0_o = tgt_0;
   assign bus.f1_pred_tgt_1_o = tgt_1;
   assign bus.f1_next_pc_o    = next_pc;
   assign bus.f1_stall_o      = clearing;

endmodule

// File: tb/tb_fetch_f1.sv
// Directed bench for fetch_f1: a training/lookup vector table plus hand-written
// sequences for reset, redirect, flush timing and reset during a flush.
module tb_fetch_f1;

`ifdef BRANCH_PRED_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif
   localparam int unsigned ENTRIES = 64;

   typedef struct {
      logic        upd_v;
      logic [31:0] upd_pc;
      logic        upd_t;
      logic [31:0] upd_tgt;
      logic [31:0] pc;
      logic        p0;
      logic [31:0] t0;
      logic        p1;
      logic [31:0] t1;
      logic [31:0] nxt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [15];

   fetch_f1_if bus ();

   fetch_f1 #(
      .RESET_PC    (32'h0000_0000),
      .BTB_ENTRIES (ENTRIES)
   ) dut (
      .clock_i   (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.frontend_we_i       = 1'b0;
      bus.exec_wrong_branch_i = 1'b0;
      bus.exec_redirect_pc_i  = '0;
      bus.upd_valid_i         = 1'b0;
      bus.upd_pc_i            = '0;
      bus.upd_taken_i         = 1'b0;
      bus.upd_target_i        = '0;
      bus.btb_flush_i         = 1'b0;
   endtask

   // One cycle of optional training plus a redirect to pc; leaves the DUT fetching pc.
   task automatic apply(input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic [31:0] pc);
      bus.upd_valid_i         = uv;
      bus.upd_pc_i            = upc;
      bus.upd_taken_i         = ut;
      bus.upd_target_i        = utgt;
      bus.exec_wrong_branch_i = 1'b1;
      bus.exec_redirect_pc_i  = pc;
      tick();
      idle();
      #1;
   endtask

   function automatic logic [31:0] bpv(input logic [31:0] v);
      return BP ? v : 32'h0;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;

      vecs[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,   32'h10,       1'b0, 32'h0,   1'b0, 32'h0,   32'h18};
      vecs[1]  = '{1'b1, 32'h10,       1'b1, 32'h100, 32'h10,       1'b1, 32'h100, 1'b0, 32'h0,   32'h100};
      vecs[2]  = '{1'b1, 32'h10,       1'b0, 32'h0,   32'h10,       1'b0, 32'h100, 1'b0, 32'h0,   32'h18};
      vecs[3]  = '{1'b1, 32'h10,       1'b0, 32'h0,   32'h10,       1'b0, 32'h100, 1'b0, 32'h0,   32'h18};
      vecs[4]  = '{1'b1, 32'h14,       1'b1, 32'h200, 32'h10,       1'b0, 32'h100, 1'b1, 32'h200, 32'h200};
      vecs[5]  = '{1'b1, 32'h10,       1'b1, 32'h100, 32'h10,       1'b0, 32'h100, 1'b1, 32'h200, 32'h200};
      vecs[6]  = '{1'b1, 32'h10,       1'b1, 32'h100, 32'h10,       1'b1, 32'h100, 1'b0, 32'h0,   32'h100};
      vecs[7]  = '{1'b1, 32'h10,       1'b1, 32'h180, 32'h10,       1'b1, 32'h180, 1'b0, 32'h0,   32'h180};
      vecs[8]  = '{1'b0, 32'h0,        1'b0, 32'h0,   32'h14,       1'b1, 32'h200, 1'b0, 32'h0,   32'h200};
      vecs[9]  = '{1'b1, 32'h110,      1'b1, 32'h300, 32'h10,       1'b0, 32'h0,   1'b1, 32'h200, 32'h200};
      vecs[10] = '{1'b1, 32'h50,       1'b0, 32'h0,   32'h50,       1'b0, 32'h0,   1'b0, 32'h0,   32'h58};
      vecs[11] = '{1'b0, 32'h0,        1'b0, 32'h0,   32'h110,      1'b1, 32'h300, 1'b0, 32'h0,   32'h300};
      vecs[12] = '{1'b1, 32'h110,      1'b0, 32'h0,   32'h10C,      1'b0, 32'h0,   1'b0, 32'h300, 32'h114};
      vecs[13] = '{1'b0, 32'h0,        1'b0, 32'h0,   32'hFFFF_FFF8, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0};
      vecs[14] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40, 32'hFFFF_FFF8, 1'b0, 32'h0,  1'b1, 32'h40,  32'h40};

      idle();
      rst_n = 1'b0;
      #1;
      check("reset pc", bus.f1_pc_o, 32'h0);
      check("reset next_pc", bus.f1_next_pc_o, 32'h8);
      check("reset stall", {31'b0, bus.f1_stall_o}, 32'h0);
      check("reset pred0", {31'b0, bus.f1_pred_0_o}, 32'h0);
      check("reset tgt1", bus.f1_pred_tgt_1_o, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // Free-running fetch from reset: 0, 8, 16 with no predictions.
      bus.frontend_we_i = 1'b1;
      #1;
      check("seq pc0", bus.f1_pc_o, 32'h0);
      tick();
      check("seq pc1", bus.f1_pc_o, 32'h8);
      check("seq pred0", {31'b0, bus.f1_pred_0_o}, 32'h0);
      tick();
      check("seq pc2", bus.f1_pc_o, 32'h10);
      check("seq pred1", {31'b0, bus.f1_pred_1_o}, 32'h0);
      idle();
      #1;

      for (int i = 0; i < 15; i++) begin
         apply(vecs[i].upd_v, vecs[i].upd_pc, vecs[i].upd_t, vecs[i].upd_tgt, vecs[i].pc);
         check($sformatf("v%0d pc", i), bus.f1_pc_o, vecs[i].pc);
         check($sformatf("v%0d pred0", i), {31'b0, bus.f1_pred_0_o}, {31'b0, BP & vecs[i].p0});
         check($sformatf("v%0d tgt0", i), bus.f1_pred_tgt_0_o, bpv(vecs[i].t0));
         check($sformatf("v%0d pred1", i), {31'b0, bus.f1_pred_1_o}, {31'b0, BP & vecs[i].p1});
         check($sformatf("v%0d tgt1", i), bus.f1_pred_tgt_1_o, bpv(vecs[i].t1));
         check($sformatf("v%0d next_pc", i), bus.f1_next_pc_o,
               BP ? vecs[i].nxt : vecs[i].pc + 32'd8);
      end

      // Update and lookup of the same entry in one cycle: lookup sees the old content.
      apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h20);
      bus.upd_valid_i  = 1'b1;
      bus.upd_pc_i     = 32'h20;
      bus.upd_taken_i  = 1'b1;
      bus.upd_target_i = 32'h400;
      #1;
      check("same-cycle pred0", {31'b0, bus.f1_pred_0_o}, 32'h0);
      check("same-cycle tgt0", bus.f1_pred_tgt_0_o, 32'h0);
      tick();
      idle();
      #1;
      check("after-update pred0", {31'b0, bus.f1_pred_0_o}, {31'b0, BP});
      check("after-update next_pc", bus.f1_next_pc_o, BP ? 32'h400 : 32'h28);

      // Redirect wins over a slot-0 prediction, loads with frontend_we low, and is idempotent.
      bus.exec_wrong_branch_i = 1'b1;
      bus.exec_redirect_pc_i  = 32'h40;
      #1;
      check("redirect next_pc", bus.f1_next_pc_o, 32'h40);
      tick();
      check("redirect pc", bus.f1_pc_o, 32'h40);
      tick();
      check("redirect repeat pc", bus.f1_pc_o, 32'h40);
      idle();
      tick();
      check("hold pc", bus.f1_pc_o, 32'h40);
      check("hold next_pc", bus.f1_next_pc_o, 32'h48);

      // Flush: exactly ENTRIES stall cycles; updates and flushes during CLEAR are ignored.
      apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h20);
      bus.btb_flush_i  = 1'b1;
      bus.upd_valid_i  = 1'b1;
      bus.upd_pc_i     = 32'h30;
      bus.upd_taken_i  = 1'b1;
      bus.upd_target_i = 32'h500;
      #1;
      check("pre-flush stall", {31'b0, bus.f1_stall_o}, 32'h0);
      tick();
      idle();
      #1;
      n = 0;
      while (bus.f1_stall_o === 1'b1 && n < 200) begin
         if (n == 5) begin
            check("clear pred0", {31'b0, bus.f1_pred_0_o}, 32'h0);
            check("clear tgt0", bus.f1_pred_tgt_0_o, 32'h0);
            check("clear next_pc", bus.f1_next_pc_o, 32'h28);
         end
         if (n == 30) begin
            bus.upd_valid_i  = 1'b1;
            bus.upd_pc_i     = 32'h14;
            bus.upd_taken_i  = 1'b1;
            bus.upd_target_i = 32'h700;
         end
         if (n == 40) bus.btb_flush_i = 1'b1;
         tick();
         idle();
         #1;
         n++;
      end
      check("flush stall cycles", n, ENTRIES);
      check("post-flush pc", bus.f1_pc_o, 32'h20);
      check("post-flush pred0", {31'b0, bus.f1_pred_0_o}, 32'h0);
      check("post-flush tgt0", bus.f1_pred_tgt_0_o, 32'h0);
      apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h10);
      check("post-flush 0x10 tgt0", bus.f1_pred_tgt_0_o, 32'h0);
      check("post-flush 0x14 pred1", {31'b0, bus.f1_pred_1_o}, 32'h0);
      check("post-flush 0x14 tgt1", bus.f1_pred_tgt_1_o, 32'h0);
      apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h30);
      check("flush-cycle update cleared", bus.f1_pred_tgt_0_o, 32'h0);

      // Reset in cycle 10 of a clear, with a trained entry the clear has not reached yet.
      apply(1'b1, 32'h80, 1'b1, 32'h900, 32'h80);
      check("train 0x80 pred0", {31'b0, bus.f1_pred_0_o}, {31'b0, BP});
      check("train 0x80 tgt0", bus.f1_pred_tgt_0_o, bpv(32'h900));
      bus.btb_flush_i = 1'b1;
      tick();
      idle();
      repeat (10) tick();
      check("mid-clear stall", {31'b0, bus.f1_stall_o}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("async reset stall", {31'b0, bus.f1_stall_o}, 32'h0);
      check("async reset pc", bus.f1_pc_o, 32'h0);
      check("async reset next_pc", bus.f1_next_pc_o, 32'h8);
      tick();
      rst_n = 1'b1;
      tick();
      check("post-reset stall", {31'b0, bus.f1_stall_o}, 32'h0);
      apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h80);
      check("post-reset 0x80 pred0", {31'b0, bus.f1_pred_0_o}, 32'h0);
      check("post-reset 0x80 tgt0", bus.f1_pred_tgt_0_o, 32'h0);
      check("post-reset 0x80 next_pc", bus.f1_next_pc_o, 32'h88);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_f1.md
# fetch_f1

First fetch stage (F1) of the dual-issue core. It owns the fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Each cycle it presents a two-instruction fetch group (PC, PC+4), per-slot taken predictions and targets to the F1/F2 pipeline buffer. Execute-stage resolution feeds it redirects and BTB training updates.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `BTB_ENTRIES`, 64, number of BTB entries; must be a power of two, 2..1024. `IDX_W = log2(BTB_ENTRIES)`.

Ports:
- `clock_i`  in  1  core clock
- `reset_n_i`  in  1  asynchronous, active-low reset
- `frontend_we_i`  in  1  pipeline frontend write enable; PC advances only when high
- `exec_wrong_branch_i`  in  1  execute-stage mispredict redirect
- `exec_redirect_pc_i`  in  32  correct next PC on redirect
- `upd_valid_i`  in  1  BTB training strobe from execute
- `upd_pc_i`  in  32  PC of the resolved branch
- `upd_taken_i`  in  1  resolved direction
- `upd_target_i`  in  32  resolved target
- `btb_flush_i`  in  1  request BTB invalidation (fence.i)
- `f1_pc_o`  out  32  fetch group PC (slot 0; slot 1 is +4)
- `f1_pred_0_o`, `f1_pred_1_o`  out  1 each  per-slot predicted taken
- `f1_pred_tgt_0_o`, `f1_pred_tgt_1_o`  out  32 each  per-slot predicted target
- `f1_next_pc_o`  out  32  PC selected for the next group
- `f1_stall_o`  out  1  high while the BTB clear is in progress

## Operation
- Lookup, combinational from `f1_pc_o` and PC+4:
  - index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`.
  - hit = valid && tag match.
  - pred = hit && ctr[1]; target output = stored target when hit, else 0.
- Slot 1 suppression: if `f1_pred_0_o` = 1, `f1_pred_1_o` is forced to 0 and `f1_pred_tgt_1_o` to 0.
- Next-PC priority:
  1. `exec_wrong_branch_i` → `exec_redirect_pc_i`
  2. `f1_pred_0_o` → tgt_0
  3. `f1_pred_1_o` → tgt_1
  4. otherwise PC+8, wrapping mod 2^32
- PC register:
  - Loads `f1_next_pc_o` when `frontend_we_i` or `exec_wrong_branch_i` is high.
  - A redirect loads the PC even while stalled; repeated redirects are idempotent.
- Training, when `upd_valid_i` is high in RUN:
  - Hit, taken: ctr saturating increment (max 3); target ← `upd_target_i`.
  - Hit, not taken: ctr saturating decrement (min 0); target kept.
  - Miss, taken: allocate (overwrite): valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no change.
- FSM RUN/CLEAR:
  - RUN → CLEAR on `btb_flush_i`; clear index ← 0.
  - CLEAR invalidates one entry per cycle; → RUN after entry `BTB_ENTRIES-1`.
  - `f1_stall_o` = 1 exactly while in CLEAR.
  - In CLEAR, updates are ignored, `btb_flush_i` is ignored, and all predictions read 0.

## Timing
- Async reset:
  - PC = `RESET_PC`, all valid bits 0, ctrs 0, FSM RUN, clear index 0.
  - All pred/target outputs 0; `f1_stall_o` 0; `f1_next_pc_o` = `RESET_PC`+8.
- Lookup is zero-latency (same cycle as `f1_pc_o`). Training becomes visible to lookups the cycle after `upd_valid_i`.
- Update and lookup to the same index in the same cycle: lookup returns the pre-update content.
- A flush occupies exactly `BTB_ENTRIES` cycles of stall. An update arriving on the same cycle as `btb_flush_i` is applied before the clear begins.
- Reset asserted mid-CLEAR aborts the clear immediately to the reset state.

## Configuration
- `BRANCH_PRED_EN` defined:
  - BTB storage, training and prediction are built as described.
- `BRANCH_PRED_EN` undefined:
  - No BTB storage is built.
  - Pred and target outputs are tied to 0; next PC is redirect or PC+8.
  - `upd_*` inputs are ignored.
  - `btb_flush_i` still produces the `BTB_ENTRIES`-cycle stall, keeping fence.i timing identical.

## Structure
- Shared package `src/defs.v`:
  - Counter encodings `CTR_SNT`=0, `CTR_WNT`=1, `CTR_WT`=2, `CTR_ST`=3.
  - FSM state encodings.
  - Default `RESET_PC`.
- Sub-module `btb`: storage, dual read ports, single training write port, clear port. `fetch_f1` holds the PC register, next-PC mux and FSM.

## Test plan
- Reset release, `frontend_we_i`=1, no updates → `f1_pc_o` sequence 0, 8, 16; all preds 0.
- Update pc=0x10, taken, tgt=0x100, then fetch 0x10 → `f1_pred_0_o`=1, tgt_0=0x100, next PC 0x100. Two not-taken updates to 0x10 → prediction 0.
- Train 0x14 taken → 0x200, fetch group 0x10 → pred_1=1, next PC 0x200. Additionally train 0x10 taken → 0x100 → pred_1 forced 0, next PC 0x100.
- `exec_wrong_branch_i`=1 with `exec_redirect_pc_i`=0x40 while `frontend_we_i`=0 and pred_0=1 → PC=0x40 next cycle.
- `btb_flush_i` pulse with `BTB_ENTRIES`=64 → `f1_stall_o` high exactly 64 cycles; all earlier-trained entries then miss; an update during the clear has no effect.
- Reset asserted in cycle 10 of a clear → stall drops and PC=`RESET_PC` asynchronously; no predictions hit afterwards.
